// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {instruction, pc} pairs with SKID-reserved stall output.
// Optional same-cycle enqueue-to-dequeue bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int SKID  = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       enq_valid,
   input  logic [31:0]                enq_instruction,
   input  logic [31:0]                enq_pc,
   output logic                       queue_full,
   input  logic                       deq_ready,
   output logic                       deq_valid,
   output logic [31:0]                deq_instruction,
   output logic [31:0]                deq_pc,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH - SKID);

   logic [63:0]   mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;

   logic byp, byp_take, nonempty, enq_fire, wr_en, rd_en;

   assign nonempty = (count_q != '0);
   assign enq_fire = enq_valid && (count_q < DEPTH_C);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = !nonempty && enq_valid && !flush;
`else
   assign byp = 1'b0;
`endif

   // A bypassed entry that is consumed immediately never touches storage.
   assign byp_take = byp && deq_ready;
   assign wr_en    = enq_fire && !byp_take && !flush;
   assign rd_en    = deq_ready && nonempty && !flush;

   assign deq_valid  = nonempty || byp;
   assign queue_full = (count_q >= FULL_C);
   assign count      = count_q;
   assign overflow   = overflow_q;

   always_comb begin
      deq_instruction = 32'b0;
      deq_pc          = 32'b0;
      if (nonempty) begin
         {deq_instruction, deq_pc} = mem_q[head_q];
      end else if (byp) begin
         deq_instruction = enq_instruction;
         deq_pc          = enq_pc;
      end
   end

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en) tail_d = tail_q + PW'(1);
         if (rd_en) head_d = head_q + PW'(1);
         count_d = count_q + CW'(wr_en) - CW'(rd_en);
         if (enq_valid && (count_q == DEPTH_C)) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[tail_q] <= {enq_instruction, enq_pc};
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
// Honors FETCH_QUEUE_BYPASS_EN the same way as the design build.
module tb_fetch_queue;

   localparam int DEPTH = 8;
   localparam int SKID  = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0, flush = 1'b0, enq_valid = 1'b0, deq_ready = 1'b0;
   logic [31:0] enq_instruction = '0, enq_pc = '0;
   logic        queue_full, deq_valid, overflow;
   logic [31:0] deq_instruction, deq_pc;
   logic [$clog2(DEPTH):0] count;

   fetch_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .enq_valid(enq_valid), .enq_instruction(enq_instruction), .enq_pc(enq_pc),
      .queue_full(queue_full), .deq_ready(deq_ready), .deq_valid(deq_valid),
      .deq_instruction(deq_instruction), .deq_pc(deq_pc),
      .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] mq[$];
   logic        m_ovf = 1'b0;
   bit          model_ok = 1'b0;
   logic [31:0] pc_ctr = 32'h0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit bypass_now();
`ifdef FETCH_QUEUE_BYPASS_EN
      return (mq.size() == 0) && enq_valid && !flush;
`else
      return 1'b0;
`endif
   endfunction

   // One clock: apply inputs, compare against model before the edge, then advance model.
   task automatic step(input logic r, input logic f, input logic ev,
                       input logic [31:0] ins, input logic [31:0] pc, input logic dr);
      int n;
      bit bp;
      logic [63:0] exp_data;
      @(negedge clk);
      reset = r; flush = f; enq_valid = ev; enq_instruction = ins; enq_pc = pc; deq_ready = dr;
      #1;
      n  = mq.size();
      bp = bypass_now();
      exp_data = (n > 0) ? mq[0] : (bp ? {ins, pc} : 64'h0);
      if (model_ok) begin
         chk("deq_valid", deq_valid, (n > 0) || bp);
         chk("deq_instr", deq_instruction, exp_data[63:32]);
         chk("deq_pc", deq_pc, exp_data[31:0]);
         chk("count", count, n);
         chk("queue_full", queue_full, n >= DEPTH - SKID);
         chk("overflow", overflow, m_ovf);
      end
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         model_ok = 1'b1;
      end else if (f) begin
         mq.delete();
      end else if (!(bp && dr)) begin
         if (ev && n == DEPTH) m_ovf = 1'b1;
         if (dr && n > 0) void'(mq.pop_front());
         if (ev && n < DEPTH) mq.push_back({ins, pc});
      end
   endtask

   task automatic enq(input logic [31:0] pc, input logic dr);
      step(1'b0, 1'b0, 1'b1, $urandom, pc, dr);
   endtask

   task automatic idle(input logic dr);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, dr);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      // reset and idle
      do_reset();
      idle(1'b0);
      #1;
      chk("t1_count", count, 0);
      chk("t1_deq_valid", deq_valid, 0);
      chk("t1_deq_pc", deq_pc, 0);
      chk("t1_full", queue_full, 0);

      // three entries then in-order drain
      enq(32'h0, 1'b0); enq(32'h4, 1'b0); enq(32'h8, 1'b0);
      #1;
      chk("t2_count", count, 3);
      chk("t2_head_pc", deq_pc, 32'h0);
      repeat (4) idle(1'b1);
      #1;
      chk("t2_empty", deq_valid, 0);

      // fill to stall threshold, full, then overflow
      do_reset();
      for (int i = 0; i < 7; i++) enq(32'h1000 + 4 * i, 1'b0);
      #1;
      chk("t3_full7", queue_full, 1);
      chk("t3_count7", count, 7);
      enq(32'h101C, 1'b0);
      #1;
      chk("t3_count8", count, 8);
      chk("t3_no_ovf", overflow, 0);
      enq(32'h1020, 1'b0);
      #1;
      chk("t3_ovf", overflow, 1);
      chk("t3_count_hold", count, 8);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t3_drain_pc", deq_pc, 32'h1000 + 4 * i);
         idle(1'b1);
      end
      #1;
      chk("t3_drained", deq_valid, 0);
      chk("t3_ovf_sticky", overflow, 1);

      // enq+deq at full: enq rejected
      do_reset();
      for (int i = 0; i < 8; i++) enq(32'h2000 + 4 * i, 1'b0);
      enq(32'h2020, 1'b1);
      #1;
      chk("t4_count", count, 7);
      chk("t4_ovf", overflow, 1);
      chk("t4_head", deq_pc, 32'h2004);

      // flush overrides concurrent enq/deq
      do_reset();
      for (int i = 0; i < 5; i++) enq(32'h3000 + 4 * i, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'hDEAD, 32'h3100, 1'b1);
      #1;
      chk("t5_count", count, 0);
      chk("t5_ovf", overflow, 0);
      enq(32'h100, 1'b0);
      #1;
      chk("t5_head", deq_pc, 32'h100);
      chk("t5_count1", count, 1);

      // wrap at steady occupancy of three
      do_reset();
      pc_ctr = 32'h4000;
      for (int i = 0; i < 3; i++) begin enq(pc_ctr, 1'b0); pc_ctr += 4; end
      for (int i = 0; i < 20; i++) begin enq(pc_ctr, 1'b1); pc_ctr += 4; end
      #1;
      chk("t6_count", count, 3);
      chk("t6_head", deq_pc, pc_ctr - 12);

`ifdef FETCH_QUEUE_BYPASS_EN
      do_reset();
      @(negedge clk);
      enq_valid = 1'b1; enq_pc = 32'h5000; enq_instruction = 32'h1234; deq_ready = 1'b1;
      #1;
      chk("byp_valid", deq_valid, 1);
      chk("byp_pc", deq_pc, 32'h5000);
      enq(32'h5000, 1'b1);
      #1;
      chk("byp_count", count, 0);
`endif

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic r, f, ev, dr;
         r  = ($urandom_range(0, 299) == 0);
         f  = ($urandom_range(0, 39) == 0);
         ev = ($urandom_range(0, 99) < ((i / 500) % 2 ? 80 : 50));
         dr = ($urandom_range(0, 99) < ((i / 300) % 2 ? 30 : 70));
         step(r, f, ev, $urandom, pc_ctr, dr);
         if (ev) pc_ctr += 4;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
